tff_count_sequencer: RTL
========================

Name: tff_count_sequencer

Overview:
Controller that sequences a bank of WIDTH toggle flip-flops as a synchronous up/down counter with a programmable terminal value. Each cycle it computes the per-bit toggle-enable vector (T inputs) from current state, direction and terminal detection, and applies it (q <= q ^ t_vec). A small run-control FSM handles start/stop, free-running wrap versus one-shot completion, and status flags. It is the sequencing layer above the single T flip-flop cell, used for timers and event counters.

Parameters:
WIDTH, 4, number of toggle flip-flop stages (counter width), legal range 2..16

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous reset, active high
start  input  1  single-cycle request to begin counting (sampled in IDLE only)
stop  input  1  abort request; forces return to IDLE
up_dn  input  1  direction, 1 = up, 0 = down; latched on accepted start
one_shot  input  1  1 = stop at terminal value, 0 = wrap and continue; latched on accepted start
limit  input  WIDTH  terminal value (up) / reload value (down); latched on accepted start
count  output  WIDTH  current T flip-flop bank state
t_vec  output  WIDTH  toggle enables applied at the next rising edge
busy  output  1  high in RUN
done  output  1  one-cycle pulse when a one-shot run reaches terminal
wrap  output  1  one-cycle pulse when a free-running count wraps

Behaviour:
- Clock is clk; reset is asynchronous, active-high; all registers clear immediately on reset assertion regardless of clk.
- Reset values: count=0, t_vec=0, busy=0, done=0, wrap=0, FSM=IDLE, latched dir/mode/limit=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: t_vec=0 (bank holds). On start=1 and stop=0: latch up_dn, one_shot, limit; next edge loads count to start value (up: 0, down: latched limit) by t_vec = count ^ start_value; go to RUN. busy rises that same edge.
- RUN, non-terminal: up: t_vec[0]=1, t_vec[i]=AND of count[i-1:0]; down: t_vec[0]=1, t_vec[i]=AND of ~count[i-1:0]. Count changes by exactly 1 per cycle.
- Terminal: up when count==latched limit; down when count==0.
- RUN at terminal, one_shot=0: t_vec = count ^ start_value (reload, not binary overflow); wrap pulses 1 cycle coincident with the reload edge; remain RUN.
- RUN at terminal, one_shot=1: t_vec=0 (count holds terminal value); go to DONE; done pulses 1 cycle in DONE; busy falls.
- DONE: lasts exactly one cycle, t_vec=0, then IDLE. count retains terminal value until the next start.
- stop=1 in RUN or DONE: next edge goes to IDLE, t_vec=0, count frozen at present value, no done/wrap pulse that cycle. stop has priority over terminal handling and start.
- start while RUN/DONE: ignored. limit/up_dn/one_shot changes during RUN: ignored (latched copies used).
- limit=0, up: terminal immediately after load; one_shot gives done 1 cycle after busy rises; free-run pulses wrap every cycle with count=0.
- Down with limit=0: same as above with terminal at 0.
- t_vec is combinational from state; count is the only datapath register; count update is strictly count_next = count ^ t_vec.
- Reset mid-RUN: immediate return to reset values; no pulses generated.

Test Plan:
- Reset: assert reset mid-RUN with count=5 -> count=0, busy=0, done=0, wrap=0 immediately, without waiting for clk.
- Up one-shot: WIDTH=4, limit=9, up_dn=1, one_shot=1, start pulse -> count 0,1,...,9 on successive cycles, t_vec at count=7 equals 4'b1111, done pulses one cycle after reaching 9, count holds 9, busy low.
- Down free-run: limit=3, up_dn=0, one_shot=0 -> count 3,2,1,0,3,2,...; wrap high on each 0->3 edge; t_vec at count=0 equals 4'b0011.
- Full-range up wrap: limit=15, free-run -> count 14,15,0 with wrap pulse on 15->0; t_vec at 15 equals 4'b1111.
- Stop priority: start up, limit=9, assert stop and start together at count=4 -> IDLE, count frozen at 4, no done; start ignored that cycle; a later start reloads 0.
- Edge limit: limit=0, up, one_shot=1 -> count=0 after load, done pulse the following cycle; with one_shot=0 -> wrap high every cycle, count stays 0.

Source files
------------

// File: rtl/tff_count_sequencer.sv
// Sequences a bank of toggle flip-flops as an up/down counter with a programmable terminal value.
// A run-control FSM handles start/stop, one-shot completion and free-running wrap with reload.
module tff_count_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             up_dn,
   input  logic             one_shot,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] t_vec,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             dir_q, dir_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic [WIDTH-1:0] count_q, count_d;

   logic [WIDTH-1:0] step_up, step_dn, start_val;
   logic             terminal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         dir_q   <= 1'b0;
         mode_q  <= 1'b0;
         limit_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         limit_q <= limit_d;
         count_q <= count_d;
      end
   end

   // Toggle enables for a +/-1 step: bit i toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      logic up_c;
      logic dn_c;
      up_c = 1'b1;
      dn_c = 1'b1;
      step_up = '0;
      step_dn = '0;
      for (int i = 0; i < WIDTH; i++) begin
         step_up[i] = up_c;
         step_dn[i] = dn_c;
         up_c = up_c & count_q[i];
         dn_c = dn_c & ~count_q[i];
      end
   end

   assign terminal  = dir_q ? (count_q == limit_q) : (count_q == '0);
   assign start_val = dir_q ? '0 : limit_q;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      limit_d = limit_q;
      t_vec   = '0;
      busy    = 1'b0;
      done    = 1'b0;
      wrap    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               dir_d   = up_dn;
               mode_d  = one_shot;
               limit_d = limit;
               t_vec   = count_q ^ (up_dn ? '0 : limit);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (stop) begin
               state_d = S_IDLE;
            end else if (terminal) begin
               if (mode_q) begin
                  state_d = S_DONE;
               end else begin
                  // Reload rather than overflow, so a limit below full scale wraps cleanly.
                  t_vec = count_q ^ start_val;
                  wrap  = 1'b1;
               end
            end else begin
               t_vec = dir_q ? step_up : step_dn;
            end
         end
         S_DONE: begin
            done    = !stop;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      count_d = count_q ^ t_vec;
   end

   assign count = count_q;

endmodule
